// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU request arbiter and the ALU unit decoder.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // ALU_FUN[3:2] unit select, shared with the ALU decoder
  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request, ALU and response signals between the command sources, the arbiter and the ALU.
interface alu_req_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) ();
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [4*NUM_REQ-1:0]          req_fun;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_a;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          alu_en;
  logic [3:0]                    alu_fun;
  logic [DATA_WIDTH-1:0]         alu_a;
  logic [DATA_WIDTH-1:0]         alu_b;
  logic [2*DATA_WIDTH-1:0]       alu_out;
  logic                          alu_out_valid;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [2*DATA_WIDTH-1:0]       rsp_data;
  logic                          rsp_err;

  // arbiter side
  modport slave (
    input  req_valid, req_fun, req_a, req_b,
    output req_ready,
    output alu_en, alu_fun, alu_a, alu_b,
    input  alu_out, alu_out_valid,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );

  // requesters, ALU and response consumer side
  modport master (
    output req_valid, req_fun, req_a, req_b,
    input  req_ready,
    input  alu_en, alu_fun, alu_a, alu_b,
    output alu_out, alu_out_valid,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above i_ptr, wrapping.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);
  localparam int IW1 = ID_W + 1;
  localparam logic [IW1-1:0] N_L = IW1'(NUM_REQ);

  logic [NUM_REQ-1:0] w_rot;
  logic [IW1-1:0]     w_off;
  logic [IW1-1:0]     w_sum;

  // rotate so bit 0 is the pointer position, then take the lowest set bit
  assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = '0;
    o_any = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = IW1'(j);
        o_any = 1'b1;
      end
    end
  end

  assign w_sum   = {1'b0, i_ptr} + w_off;
  assign o_idx   = (w_sum >= N_L) ? ID_W'(w_sum - N_L) : ID_W'(w_sum);
  assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/alu_req_arbiter.sv
// Time-shares one ALU among NUM_REQ requesters: round-robin accept, one-cycle issue,
// wait for result or timeout, then hold the response until the consumer takes it.
//   state | meaning
//   IDLE  | arbitrate; on a grant latch the winner's op and advance the pointer
//   ISSUE | ALU_EN high for this cycle; clear timeout counter
//   WAIT  | count cycles; take ALU result or give up after TIMEOUT
//   RESP  | response valid and frozen until RSP_READY
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 15
) (
  input logic              i_clk,
  input logic              i_rst,
  alu_req_arbiter_if.slave io_bus
);
  localparam int ID_W = id_width(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [7:0]      TO_CNT  = 8'(TIMEOUT);

  state_t                  r_state;
  logic [ID_W-1:0]         r_ptr;
  logic [7:0]              r_cnt;
  logic                    r_alu_en;
  logic [3:0]              r_alu_fun;
  logic [DATA_WIDTH-1:0]   r_alu_a;
  logic [DATA_WIDTH-1:0]   r_alu_b;
  logic                    r_rsp_valid;
  logic [ID_W-1:0]         r_rsp_id;
  logic [2*DATA_WIDTH-1:0] r_rsp_data;
  logic                    r_rsp_err;

  logic [NUM_REQ-1:0]      w_grant;
  logic [ID_W-1:0]         w_gidx;
  logic                    w_any;
  logic [3:0]              w_fun;
  logic [DATA_WIDTH-1:0]   w_a;
  logic [DATA_WIDTH-1:0]   w_b;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (io_bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  always_comb begin
    w_fun = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_fun = io_bus.req_fun[4*i +: 4];
        w_a   = io_bus.req_a[DATA_WIDTH*i +: DATA_WIDTH];
        w_b   = io_bus.req_b[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // accept strobe is combinational so the handshake lands on the grant edge
  assign io_bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_alu_en    <= 1'b0;
      r_alu_fun   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_alu_en <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_alu_fun <= w_fun;
            r_alu_a   <= w_a;
            r_alu_b   <= w_b;
            r_rsp_id  <= w_gidx;
            r_ptr     <= (w_gidx == LAST_ID) ? '0 : w_gidx + 1'b1;
            r_alu_en  <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // a result arriving on the timeout cycle still wins
          if (io_bus.alu_out_valid) begin
            r_rsp_data  <= io_bus.alu_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_cnt == TO_CNT) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.alu_en    = r_alu_en;
  assign io_bus.alu_fun   = r_alu_fun;
  assign io_bus.alu_a     = r_alu_a;
  assign io_bus.alu_b     = r_alu_b;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_id    = r_rsp_id;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed and randomized bench for alu_req_arbiter with a stand-in ALU of programmable latency.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  alu_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int n_err = 0;
  int n_chk = 0;
  int m_ptr = 0;

  logic [3:0]  p_fun [NR];
  logic [7:0]  p_a   [NR];
  logic [7:0]  p_b   [NR];
  logic [3:0]  units_seen = '0;

  // stand-in ALU: result valid alu_delay cycles after ALU_EN, never if alu_delay is 0
  int          alu_delay = 0;
  int          cd = 0;
  logic        alu_v = 1'b0;
  logic        spur = 1'b0;
  logic [15:0] alu_res = '0;
  logic [15:0] alu_hold = '0;

  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    if (f[3:2] == 2'b00)
      return (f[1:0] == 2'b00) ? 16'(a) + 16'(b) : 16'(a) * 16'(b) + 16'(f);
    return {f, 4'h0, a ^ b};
  endfunction

  assign bus.alu_out_valid = alu_v | spur;
  assign bus.alu_out       = alu_res;

  always @(posedge clk) begin
    alu_v <= 1'b0;
    if (bus.alu_en) begin
      alu_hold <= alu_ref(bus.alu_fun, bus.alu_a, bus.alu_b);
      if (alu_delay == 1) begin
        alu_v   <= 1'b1;
        alu_res <= alu_ref(bus.alu_fun, bus.alu_a, bus.alu_b);
        cd      <= 0;
      end else begin
        cd <= (alu_delay > 1) ? alu_delay - 1 : 0;
      end
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        alu_v   <= 1'b1;
        alu_res <= alu_hold;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_payload();
    for (int i = 0; i < NR; i++) begin
      bus.req_fun[i*4 +: 4]  = p_fun[i];
      bus.req_a[i*DW +: DW]  = p_a[i];
      bus.req_b[i*DW +: DW]  = p_b[i];
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int g);
    return NR'(1) << g;
  endfunction

  // rule: first asserted request at or after the pointer, wrapping upward
  function automatic int model_grant(input logic [NR-1:0] m);
    logic [NR-1:0] t;
    for (int k = 0; k < NR; k++) begin
      t = m >> ((m_ptr + k) % NR);
      if (t[0]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  // one full transaction starting in an IDLE cycle; returns the DUT's RSP_ID
  task automatic run_op(input logic [NR-1:0] mask, input int d, input int bp, output int id_seen);
    int          g;
    int          lat;
    logic [3:0]  e_fun;
    logic [7:0]  e_a, e_b;
    logic [15:0] e_data;
    logic        e_err;
    logic [NR-1:0] left;

    alu_delay     = d;
    bus.req_valid = mask;
    #1;
    g = model_grant(mask);
    check("idle_req_ready", 32'(bus.req_ready), 32'(onehot(g)));
    e_fun = p_fun[g];
    e_a   = p_a[g];
    e_b   = p_b[g];
    if (d >= 1 && d <= TO + 1) begin
      lat = d + 1; e_err = 1'b0; e_data = alu_ref(e_fun, e_a, e_b);
    end else begin
      lat = TO + 2; e_err = 1'b1; e_data = '0;
    end
    m_ptr = (g + 1) % NR;

    tick();
    left          = mask & ~onehot(g);
    bus.req_valid = left;
    p_fun[g] = 4'($urandom); p_a[g] = 8'($urandom); p_b[g] = 8'($urandom);
    drive_payload();
    #1;
    check("issue_en_ready", {26'd0, bus.alu_en, bus.rsp_valid, bus.req_ready}, {26'd0, 1'b1, 1'b0, 4'b0000});
    check("issue_fun", 32'(bus.alu_fun), 32'(e_fun));
    check("issue_ab", {16'd0, bus.alu_a, bus.alu_b}, {16'd0, e_a, e_b});
    if (bus.alu_fun[3:2] == ARITH) units_seen[0] = 1'b1;
    if (bus.alu_fun[3:2] == LOGIC) units_seen[1] = 1'b1;
    if (bus.alu_fun[3:2] == CMP)   units_seen[2] = 1'b1;
    if (bus.alu_fun[3:2] == SHIFT) units_seen[3] = 1'b1;

    for (int c = 1; c < lat; c++) begin
      tick();
      check("wait_quiet", {26'd0, bus.alu_en, bus.rsp_valid, bus.req_ready}, 32'd0);
    end

    tick();
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_id", 32'(bus.rsp_id), 32'(g));
    check("rsp_data", 32'(bus.rsp_data), 32'(e_data));
    check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
    id_seen = int'(bus.rsp_id);

    for (int c = 0; c < bp; c++) begin
      bus.rsp_ready = 1'b0;
      tick();
      check("bp_hold", {bus.rsp_valid, 2'(bus.rsp_id), bus.rsp_data, bus.rsp_err},
                       {1'b1, 2'(g), e_data, e_err});
      check("bp_ready_low", 32'(bus.req_ready), 32'd0);
    end

    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    check("after_handshake", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int id;
    logic [NR-1:0] m;

    for (int i = 0; i < NR; i++) begin
      p_fun[i] = 4'($urandom); p_a[i] = 8'($urandom); p_b[i] = 8'($urandom);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    drive_payload();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_outputs", {bus.alu_en, bus.alu_fun, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_err}, '0);
    check("reset_rsp", {14'd0, bus.rsp_id, bus.rsp_data}, 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);

    // single request from requester 2
    p_fun[2] = 4'b0000; p_a[2] = 8'h12; p_b[2] = 8'h34;
    drive_payload();
    run_op(4'b0100, 1, 0, id);
    check("single_id", 32'(id), 32'd2);

    // fairness after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0;
    for (int i = 0; i < 8; i++) begin
      run_op(4'b1111, 1, 0, id);
      check("fair_order", 32'(id), 32'(i % 4));
    end

    // timeout, valid-on-timeout-cycle, valid one cycle too late, then normal service
    run_op(4'b0001, 0, 0, id);
    run_op(4'b0010, TO + 1, 0, id);
    run_op(4'b0100, TO + 2, 0, id);
    run_op(4'b1000, 1, 0, id);

    // backpressure with other requests pending
    run_op(4'b1111, 2, 10, id);
    run_op(4'b1111, 1, 0, id);

    // opcode passthrough over all 16 codes
    units_seen = '0;
    for (int c = 0; c < 16; c++) begin
      int r;
      r = m_ptr;
      p_fun[r] = 4'(c);
      drive_payload();
      run_op(onehot(r), 1, 0, id);
    end
    check("units_covered", 32'(units_seen), 32'hF);

    // reset in WAIT aborts silently; a stray strobe afterwards is ignored
    alu_delay = 0;
    bus.req_valid = 4'b0101;
    tick();
    bus.req_valid = '0;
    tick();
    check("mid_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_outputs", {bus.alu_en, bus.alu_fun, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_err}, '0);
    check("abort_rsp", {14'd0, bus.rsp_id, bus.rsp_data}, 32'd0);
    m_ptr = 0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("spurious_ignored", {30'd0, bus.rsp_valid, bus.alu_en}, 32'd0);
    end
    run_op(4'b1010, 1, 0, id);
    check("post_reset_lowest", 32'(id), 32'd1);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      int d;
      m = NR'($urandom_range(1, 15));
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      run_op(m, d, int'($urandom_range(0, 3)), id);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
